sample_block_writer: RTL

- Upstream stage of the encoder's 8192-word dual-write sample RAM.
- Accepts a stream of 16-bit audio sample pairs and writes each pair in one cycle through the RAM's two write ports.
- Packs samples into fixed-size blocks, ping-ponging between the low half (0..4095) and the high half (4096..8191).
- Hands completed blocks to the downstream analysis stage with a valid/ack handshake.

---
 rtl/sample_block_writer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sample_block_writer.sv
// ---------------------------------------------------------------------------
// sample_block_writer
//
// Upstream stage of the encoder's 8192-word dual-write sample RAM. Each
// accepted sample pair is written in a single cycle through the RAM's two
// write ports. Samples are packed into blocks that alternate between the
// low half-buffer (base 0) and the high half-buffer (base HALF_BASE).
// Completed blocks are offered to the analysis stage through a valid/ack
// handshake, oldest first, with at most two blocks outstanding.
//
// Ports
//   iClock          clock, all logic on the rising edge
//   iReset          synchronous reset, active-high
//   iValid          sample pair valid
//   iSample1        even-index sample of the pair
//   iSample2        odd-index sample of the pair
//   iLast           with iValid: this pair closes the current block early
//   oReady          pair is accepted in a cycle where iValid && oReady
//   oWE1 / oWE2     RAM write enables (one cycle after the accept)
//   oWriteAddress1  RAM write address, port 1 (even sample)
//   oWriteAddress2  RAM write address, port 2 (odd sample)
//   oData1 / oData2 RAM write data
//   oBlockValid     a completed block is resident in RAM
//   oBlockBase      base address of the oldest completed block
//   oBlockLength    sample count of that block
//   iBlockAck       consumer has finished with the presented block
// ---------------------------------------------------------------------------
module sample_block_writer #(
    parameter int BLOCK_SIZE = 4096,
    parameter int HALF_BASE  = 4096
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iValid,
    input  logic [15:0] iSample1,
    input  logic [15:0] iSample2,
    input  logic        iLast,
    output logic        oReady,
    output logic        oWE1,
    output logic        oWE2,
    output logic [15:0] oWriteAddress1,
    output logic [15:0] oWriteAddress2,
    output logic [15:0] oData1,
    output logic [15:0] oData2,
    output logic        oBlockValid,
    output logic [15:0] oBlockBase,
    output logic [15:0] oBlockLength,
    input  logic        iBlockAck
);

    // Index of the pair that fills a block to BLOCK_SIZE samples.
    localparam logic [15:0] K_LAST    = 16'(BLOCK_SIZE / 2 - 1);
    localparam logic [15:0] HIGH_BASE = 16'(HALF_BASE);

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_t;

    // Word address of a half-buffer (0 = low, 1 = high).
    function automatic logic [15:0] half_base(input logic half);
        return half ? HIGH_BASE : 16'd0;
    endfunction

    // Sample count of a block whose last accepted pair had index k.
    function automatic logic [15:0] block_length(input logic [15:0] k);
        return (k << 1) + 16'd2;
    endfunction

    state_t      state;
    logic        fill_half;      // half currently being written
    logic        read_half;      // half holding the oldest completed block
    logic [1:0]  full_q;         // per-half: completed block resident in RAM
    logic [15:0] len_q [2];      // per-half: length of its completed block
    logic [15:0] pair_cnt;       // pair index k within the block being filled

    // Completion travels one stage behind the accept so the block only
    // becomes visible once its last pair has been written to RAM.
    logic        blk_vld_p1;
    logic        blk_half_p1;
    logic [15:0] blk_len_p1;

    logic        accept;
    logic        ack_take;
    logic        complete;
    logic        next_half;
    logic        next_blocked;
    logic        fill_free;
    logic [15:0] wr_addr;
    logic [15:0] blk_len;

    always_comb begin
        accept    = iValid && oReady;
        // An ack only counts while a block is actually being presented.
        ack_take  = iBlockAck && full_q[read_half];
        complete  = accept && (iLast || (pair_cnt == K_LAST));
        next_half = ~fill_half;
        wr_addr   = half_base(fill_half) + (pair_cnt << 1);
        blk_len   = block_length(pair_cnt);

        // A half is busy while its block is resident or still in the write
        // stage; an ack on this same edge releases the read half.
        next_blocked = (full_q[next_half] ||
                        (blk_vld_p1 && (blk_half_p1 == next_half))) &&
                       !(ack_take && (read_half == next_half));

        fill_free = !(full_q[fill_half] ||
                      (blk_vld_p1 && (blk_half_p1 == fill_half))) ||
                    (ack_take && (read_half == fill_half));
    end

    // ---- stage p0 -> p1: accept, RAM write, block bookkeeping ----
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state          <= FILL;
            oReady         <= 1'b0;
            fill_half      <= 1'b0;
            read_half      <= 1'b0;
            full_q         <= 2'b00;
            len_q[0]       <= 16'd0;
            len_q[1]       <= 16'd0;
            pair_cnt       <= 16'd0;
            blk_vld_p1     <= 1'b0;
            blk_half_p1    <= 1'b0;
            blk_len_p1     <= 16'd0;
            oWE1           <= 1'b0;
            oWE2           <= 1'b0;
            oWriteAddress1 <= 16'd0;
            oWriteAddress2 <= 16'd0;
            oData1         <= 16'd0;
            oData2         <= 16'd0;
        end else begin
            // RAM write port: enables pulse per accept, address/data hold.
            oWE1 <= accept;
            oWE2 <= accept;
            if (accept) begin
                oWriteAddress1 <= wr_addr;
                oWriteAddress2 <= wr_addr + 16'd1;
                oData1         <= iSample1;
                oData2         <= iSample2;
            end

            blk_vld_p1 <= complete;
            if (complete) begin
                blk_half_p1 <= fill_half;
                blk_len_p1  <= blk_len;
            end

            // ---- stage p1 -> p2: block becomes visible after its RAM write ----
            if (ack_take) begin
                full_q[read_half] <= 1'b0;
                read_half         <= ~read_half;
            end
            if (blk_vld_p1) begin
                full_q[blk_half_p1] <= 1'b1;
                len_q[blk_half_p1]  <= blk_len_p1;
            end

            if (accept) begin
                if (complete) begin
                    pair_cnt  <= 16'd0;
                    fill_half <= ~fill_half;
                end else begin
                    pair_cnt <= pair_cnt + 16'd1;
                end
            end

            case (state)
                FILL: begin
                    if (complete && next_blocked) begin
                        state  <= STALL;
                        oReady <= 1'b0;
                    end else begin
                        oReady <= 1'b1;
                    end
                end
                STALL: begin
                    if (fill_free) begin
                        state  <= FILL;
                        oReady <= 1'b1;
                    end else begin
                        oReady <= 1'b0;
                    end
                end
                default: begin
                    state  <= FILL;
                    oReady <= 1'b0;
                end
            endcase
        end
    end

    // Presentation side reflects the oldest resident block.
    assign oBlockValid  = full_q[read_half];
    assign oBlockBase   = half_base(read_half);
    assign oBlockLength = len_q[read_half];

endmodule
